fifo_receiver: RTL

Downstream stage of the byte-stream path: drains the 8-bit FIFO that the sender fills. It parses the stream into frames, re-emits payload bytes and checks each frame's checksum. It reports a per-frame OK/error status and keeps saturating OK/error counters. It runs entirely in the pll99_outclk_0 domain, on the read side of a legacy-mode (non-showahead) single-clock FIFO.

---
 rtl/fifo_receiver_pkg.sv | 13 +
 rtl/sat_counter.sv | 23 ++
 rtl/fifo_receiver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo_receiver_pkg.sv
// Shared types and constants for the byte-stream frame receiver.
package fifo_receiver_pkg;

   typedef enum logic [1:0] {
      HUNT,
      LEN,
      PAYLOAD,
      CSUM
   } state_t;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         pll99_outclk_0,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pll99_outclk_0 or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_receiver.sv
// Drains a legacy-mode FIFO, parses HEADER/LEN/payload/CSUM frames, emits payload
// bytes and a per-frame status, and keeps saturating good/bad frame counters.
module fifo_receiver
   import fifo_receiver_pkg::*;
#(
   parameter logic [7:0] HEADER         = DEFAULT_HEADER,
   parameter int         TIMEOUT_CYCLES = 1024,
   parameter int         CNT_W          = 16
) (
   input  logic             pll99_outclk_0,
   input  logic             rst_n,
   output logic             fifo_rdreq,
   input  logic [7:0]       fifo_q,
   input  logic             fifo_empty,
   output logic             payload_valid,
   output logic [7:0]       payload_data,
   output logic             frame_valid,
   output logic             frame_ok,
   output logic [7:0]       frame_len,
   output logic [CNT_W-1:0] ok_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int               TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t           state, state_nxt;
   logic             rd_vld;
   logic [7:0]       len_q, len_nxt;
   logic [7:0]       rem_q, rem_nxt;
   logic [7:0]       acc_q, acc_nxt;
   logic [TMO_W-1:0] tmo_q, tmo_nxt;
   logic             timeout;
   logic             pv_nxt, fv_nxt, fok_nxt;
   logic [7:0]       pdata_nxt, flen_nxt;

   // Reading is never gated by parser state, so the FIFO can only be over-read if it lies about empty.
   assign fifo_rdreq = !fifo_empty && rst_n;

   // Fires on the cycle the idle count would reach TIMEOUT_CYCLES, so the status lands one cycle later.
   assign timeout = (state != HUNT) && (tmo_q == TMO_LAST);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      rem_nxt   = rem_q;
      acc_nxt   = acc_q;
      tmo_nxt   = (rd_vld || state == HUNT) ? '0 : tmo_q + 1'b1;
      pv_nxt    = 1'b0;
      pdata_nxt = payload_data;
      fv_nxt    = 1'b0;
      fok_nxt   = 1'b0;
      flen_nxt  = frame_len;

      if (timeout) begin
         fv_nxt    = 1'b1;
         flen_nxt  = (state == LEN) ? 8'd0 : len_q;
         tmo_nxt   = '0;
         // A byte landing with the timeout is judged as if already back in HUNT.
         state_nxt = (rd_vld && fifo_q == HEADER) ? LEN : HUNT;
      end else if (rd_vld) begin
         case (state)
            HUNT: begin
               if (fifo_q == HEADER) state_nxt = LEN;
            end
            LEN: begin
               len_nxt   = fifo_q;
               rem_nxt   = fifo_q;
               acc_nxt   = 8'd0;
               state_nxt = (fifo_q == 8'd0) ? CSUM : PAYLOAD;
            end
            PAYLOAD: begin
               acc_nxt   = acc_q + fifo_q;
               rem_nxt   = rem_q - 1'b1;
               pv_nxt    = 1'b1;
               pdata_nxt = fifo_q;
               if (rem_q == 8'd1) state_nxt = CSUM;
            end
            CSUM: begin
               fv_nxt    = 1'b1;
               fok_nxt   = (fifo_q == acc_q);
               flen_nxt  = len_q;
               state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge pll99_outclk_0 or negedge rst_n) begin
      if (!rst_n) begin
         state         <= HUNT;
         rd_vld        <= 1'b0;
         len_q         <= 8'd0;
         rem_q         <= 8'd0;
         acc_q         <= 8'd0;
         tmo_q         <= '0;
         payload_valid <= 1'b0;
         payload_data  <= 8'd0;
         frame_valid   <= 1'b0;
         frame_ok      <= 1'b0;
         frame_len     <= 8'd0;
      end else begin
         state         <= state_nxt;
         rd_vld        <= fifo_rdreq;
         len_q         <= len_nxt;
         rem_q         <= rem_nxt;
         acc_q         <= acc_nxt;
         tmo_q         <= tmo_nxt;
         payload_valid <= pv_nxt;
         payload_data  <= pdata_nxt;
         frame_valid   <= fv_nxt;
         frame_ok      <= fok_nxt;
         frame_len     <= flen_nxt;
      end
   end

   sat_counter #(.W(CNT_W)) u_ok_cnt (
      .pll99_outclk_0 (pll99_outclk_0),
      .rst_n          (rst_n),
      .clr            (1'b0),
      .inc            (fv_nxt && fok_nxt),
      .count          (ok_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .pll99_outclk_0 (pll99_outclk_0),
      .rst_n          (rst_n),
      .clr            (1'b0),
      .inc            (fv_nxt && !fok_nxt),
      .count          (err_cnt)
   );

endmodule
